if_restart_arbiter: RTL and testbench

Restart arbiter and redirect sequencer for the instruction-fetch stage. It takes the four restart sources (pipeline flush, invalid prediction, invalid instruction, function return) and selects one by fixed priority. It holds the winning request while the icache is blocked on a miss, then issues a single redirect PC to the PC generator over a valid/ready handshake. It sits between the backend/decode restart signals and the fetch PC mux, and enforces ordering that the fetch datapath assumes.

---
 rtl/if_restart_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_if_restart_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_restart_arbiter.sv
// if_restart_arbiter
// Restart arbiter and redirect sequencer for the instruction-fetch stage.
// Four restart sources are ranked by fixed priority:
// must_flush > invalid_prediction > invalid_instruction > is_return_in.
// The winning request is held while the icache is blocked on a miss. It is
// then offered to the PC generator as a single redirect.
//
// Handshake: restart_valid/restart_ready use strict valid/ready semantics.
// A redirect transfers on any rising edge where both are high. While
// restart_valid is high, restart_pc and restart_cause stay stable. The one
// exception is a must_flush, which overrides a held low-tier redirect or
// replaces the target of a held flush.
//
// Optional feature: define IF_RESTART_STATS_EN to add saturating per-cause
// handshake counters and a counter of requests seen while in HOLD.
// fsm_state exposes the FSM encoding (0 IDLE, 1 HOLD, 2 ISSUE) for checkers.
module if_restart_arbiter #(
  parameter int PC_BITS = 32,
  parameter int STAT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               must_flush,
  input  logic [PC_BITS-1:0] correct_address,
  input  logic               invalid_prediction,
  input  logic               invalid_instruction,
  input  logic               is_return_in,
  input  logic [PC_BITS-1:0] old_PC,
  input  logic [PC_BITS-1:0] ras_target,
  input  logic               icache_miss,
  output logic               restart_valid,
  input  logic               restart_ready,
  output logic [PC_BITS-1:0] restart_pc,
  output logic [1:0]         restart_cause,
  output logic               flush_fetch,
  output logic               btb_invalidate,
  output logic               multi_restart_err,
`ifdef IF_RESTART_STATS_EN
  output logic [STAT_W-1:0]  stat_flush,
  output logic [STAT_W-1:0]  stat_inv_pred,
  output logic [STAT_W-1:0]  stat_inv_instr,
  output logic [STAT_W-1:0]  stat_return,
  output logic [STAT_W-1:0]  stat_held,
`endif
  output logic [1:0]         fsm_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;

  localparam logic [1:0] CAUSE_FLUSH     = 2'd0;
  localparam logic [1:0] CAUSE_INV_PRED  = 2'd1;
  localparam logic [1:0] CAUSE_INV_INSTR = 2'd2;
  localparam logic [1:0] CAUSE_RETURN    = 2'd3;

  // Reject a zero-width statistics counter at elaboration time.
  if (STAT_W < 1) begin : g_bad_stat_w
    $error("STAT_W must be at least 1");
  end

  logic [1:0]         state;
  logic [1:0]         state_nx;
  logic [PC_BITS-1:0] pc_nx;
  logic [1:0]         cause_nx;
  logic               flush_nx;
  logic               btb_nx;

  logic               low_any;
  logic               any_req;
  logic [1:0]         low_cnt;
  logic               handshake;
  logic               can_accept;
  logic [PC_BITS-1:0] win_pc;
  logic [1:0]         win_cause;

  assign low_any   = invalid_prediction | invalid_instruction | is_return_in;
  assign any_req   = must_flush | low_any;
  assign low_cnt   = {1'b0, invalid_prediction} + {1'b0, invalid_instruction}
                   + {1'b0, is_return_in};
  assign handshake = restart_valid & restart_ready;
  // A request in the handshake cycle is a fresh request, exactly as from IDLE.
  // Any unused encoding also behaves as IDLE.
  assign can_accept = ((state != ST_HOLD) && (state != ST_ISSUE)) || handshake;
  assign fsm_state  = state;

  // Fixed-priority selection of this cycle's winning request.
  always_comb begin
    win_pc    = ras_target;
    win_cause = CAUSE_RETURN;
    if (must_flush) begin
      win_pc    = correct_address;
      win_cause = CAUSE_FLUSH;
    end else if (invalid_prediction) begin
      win_pc    = old_PC;
      win_cause = CAUSE_INV_PRED;
    end else if (invalid_instruction) begin
      win_pc    = old_PC;
      win_cause = CAUSE_INV_INSTR;
    end
  end

  // Next-state, held-request and pulse decode.
  always_comb begin
    state_nx = state;
    pc_nx    = restart_pc;
    cause_nx = restart_cause;
    flush_nx = 1'b0;
    btb_nx   = 1'b0;
    if (handshake) begin
      state_nx = ST_IDLE;
      btb_nx   = (restart_cause == CAUSE_INV_PRED);
    end
    if (can_accept) begin
      if (any_req) begin
        pc_nx    = win_pc;
        cause_nx = win_cause;
        flush_nx = 1'b1;
        state_nx = icache_miss ? ST_HOLD : ST_ISSUE;
      end
    end else begin
      // Something is held. Only a flush may displace it, because it belongs
      // to an older point in the pipeline. Later low-tier requests are dropped.
      if (must_flush) begin
        pc_nx    = correct_address;
        cause_nx = CAUSE_FLUSH;
        flush_nx = 1'b1;
      end
      if ((state == ST_HOLD) && !icache_miss) begin
        state_nx = ST_ISSUE;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      restart_valid     <= 1'b0;
      restart_pc        <= '0;
      restart_cause     <= CAUSE_FLUSH;
      flush_fetch       <= 1'b0;
      btb_invalidate    <= 1'b0;
      multi_restart_err <= 1'b0;
    end else begin
      state          <= state_nx;
      restart_valid  <= (state_nx == ST_ISSUE);
      restart_pc     <= pc_nx;
      restart_cause  <= cause_nx;
      flush_fetch    <= flush_nx;
      btb_invalidate <= btb_nx;
      if (low_cnt >= 2'd2) begin
        multi_restart_err <= 1'b1;
      end
    end
  end

`ifdef IF_RESTART_STATS_EN
  // Saturating per-cause handshake counters and a HOLD-arrival counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_flush     <= '0;
      stat_inv_pred  <= '0;
      stat_inv_instr <= '0;
      stat_return    <= '0;
      stat_held      <= '0;
    end else begin
      if (handshake) begin
        case (restart_cause)
          CAUSE_FLUSH:     if (stat_flush != '1)     stat_flush     <= stat_flush + 1'b1;
          CAUSE_INV_PRED:  if (stat_inv_pred != '1)  stat_inv_pred  <= stat_inv_pred + 1'b1;
          CAUSE_INV_INSTR: if (stat_inv_instr != '1) stat_inv_instr <= stat_inv_instr + 1'b1;
          default:         if (stat_return != '1)    stat_return    <= stat_return + 1'b1;
        endcase
      end
      if ((state == ST_HOLD) && any_req && (stat_held != '1)) begin
        stat_held <= stat_held + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_restart_arbiter.sv
// Testbench for if_restart_arbiter: directed scenarios followed by random
// traffic. The reference model tracks a single held redirect record. A
// scoreboard queue holds the redirects expected to transfer, and a monitor
// pops from it on every observed handshake.
module tb_if_restart_arbiter;
  localparam int PW = 32;

  // Clock and reset signals
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          must_flush, invalid_prediction, invalid_instruction, is_return_in;
  logic          icache_miss, restart_ready;
  logic [PW-1:0] correct_address, old_PC, ras_target;
  logic          restart_valid, flush_fetch, btb_invalidate, multi_restart_err;
  logic [PW-1:0] restart_pc;
  logic [1:0]    restart_cause, fsm_state;

  if_restart_arbiter #(.PC_BITS(PW), .STAT_W(16)) dut (
    .clk(clk), .rst(rst),
    .must_flush(must_flush), .correct_address(correct_address),
    .invalid_prediction(invalid_prediction), .invalid_instruction(invalid_instruction),
    .is_return_in(is_return_in), .old_PC(old_PC), .ras_target(ras_target),
    .icache_miss(icache_miss), .restart_valid(restart_valid), .restart_ready(restart_ready),
    .restart_pc(restart_pc), .restart_cause(restart_cause), .flush_fetch(flush_fetch),
    .btb_invalidate(btb_invalidate), .multi_restart_err(multi_restart_err),
    .fsm_state(fsm_state)
  );

  int checks = 0;
  int errors = 0;
  logic [PW+1:0] exp_q[$];

  // Reference model: one optional held redirect, either waiting on the miss
  // (m_hold) or offered to the PC generator (m_valid).
  logic          m_valid = 1'b0, m_hold = 1'b0, m_ff = 1'b0, m_btb = 1'b0, m_err = 1'b0;
  logic [PW-1:0] m_pc = '0;
  logic [1:0]    m_cause = 2'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the rules to the inputs that the last edge consumed.
  task automatic model_step();
    logic [3:0]    req;
    logic [PW-1:0] tgt[4];
    int            win;
    int            n_low;
    bit            hs;
    bit            free;
    req    = {is_return_in, invalid_instruction, invalid_prediction, must_flush};
    tgt[0] = correct_address;
    tgt[1] = old_PC;
    tgt[2] = old_PC;
    tgt[3] = ras_target;
    m_ff   = 1'b0;
    m_btb  = 1'b0;
    if (rst) begin
      m_valid = 1'b0; m_hold = 1'b0; m_pc = '0; m_cause = 2'd0; m_err = 1'b0;
      return;
    end
    n_low = int'(req[1]) + int'(req[2]) + int'(req[3]);
    if (n_low >= 2) m_err = 1'b1;
    win = -1;
    for (int k = 3; k >= 0; k--) if (req[k]) win = k;
    hs   = m_valid && restart_ready;
    free = !(m_valid || m_hold) || hs;
    if (hs) begin
      m_btb   = (m_cause == 2'd1);
      m_valid = 1'b0;
    end
    if (free) begin
      if (win >= 0) begin
        m_pc    = tgt[win];
        m_cause = 2'(win);
        m_ff    = 1'b1;
        m_hold  = icache_miss;
        m_valid = !icache_miss;
      end
    end else begin
      if (req[0]) begin
        m_pc    = tgt[0];
        m_cause = 2'd0;
        m_ff    = 1'b1;
      end
      if (m_hold && !icache_miss) begin
        m_hold  = 1'b0;
        m_valid = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    check("restart_valid", restart_valid, m_valid);
    check("flush_fetch", flush_fetch, m_ff);
    check("btb_invalidate", btb_invalidate, m_btb);
    check("multi_restart_err", multi_restart_err, m_err);
    if (m_valid) begin
      check("restart_pc", restart_pc, m_pc);
      check("restart_cause", restart_cause, m_cause);
    end
  endtask

  // Driver: apply one cycle of inputs, then advance and check the model.
  task automatic drive(input logic r, input logic mf, input logic [PW-1:0] ca,
                       input logic ip, input logic ii, input logic ir,
                       input logic [PW-1:0] op, input logic [PW-1:0] rt,
                       input logic miss, input logic rdy);
    rst = r; must_flush = mf; correct_address = ca;
    invalid_prediction = ip; invalid_instruction = ii; is_return_in = ir;
    old_PC = op; ras_target = rt; icache_miss = miss; restart_ready = rdy;
    if (!r && m_valid && rdy) exp_q.push_back({m_cause, m_pc});
    @(posedge clk);
    #1;
    model_step();
    check_outputs();
  endtask

  task automatic idle(input logic miss, input logic rdy);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, miss, rdy);
  endtask

  // Monitor: every observed handshake must match the oldest expected redirect.
  initial begin
    logic [PW+1:0] e;
    forever begin
      @(negedge clk);
      if (restart_valid && restart_ready && !rst) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL handshake: got %0h unexpected, expected none at %0t",
                   {restart_cause, restart_pc}, $time);
        end else begin
          e = exp_q.pop_front();
          check("handshake", {restart_cause, restart_pc}, e);
        end
      end
    end
  end

  // Stimulus and final report.
  initial begin
    int miss_left;
    rst = 1'b1; must_flush = 1'b0; invalid_prediction = 1'b0; invalid_instruction = 1'b0;
    is_return_in = 1'b0; icache_miss = 1'b0; restart_ready = 1'b0;
    correct_address = '0; old_PC = '0; ras_target = '0;
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    check("reset_pc", restart_pc, 0);
    check("reset_cause", restart_cause, 0);
    check("reset_state", fsm_state, 0);

    // Invalid prediction with no miss: issue next cycle, BTB pulse after handshake.
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 32'h40, '0, 1'b0, 1'b1);
    check("tp1_pc", restart_pc, 32'h40);
    check("tp1_cause", restart_cause, 1);
    idle(1'b0, 1'b1);
    check("tp1_btb", btb_invalidate, 1);
    idle(1'b0, 1'b1);

    // Invalid instruction during a 5-cycle miss.
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 32'h80, '0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b1);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);

    // Held return overridden by a flush while the miss continues.
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, '0, 32'h100, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    drive(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    idle(1'b0, 1'b0);
    check("tp3_pc", restart_pc, 32'h200);
    check("tp3_cause", restart_cause, 0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);

    // Simultaneous low-tier requests: inv_pred wins and the error latches.
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h44, 32'h300, 1'b0, 1'b0);
    check("tp4_cause", restart_cause, 1);

    // Ready low for 4 cycles, then a low-tier request arrives and is ignored.
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 32'h99, '0, 1'b0, 1'b0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
    check("tp5_state_idle", fsm_state, 0);
    check("tp4_err_sticky", multi_restart_err, 1);

    // Reset during HOLD: no redirect after the miss clears.
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 32'h500, '0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    check("tp6_state_idle", fsm_state, 0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);

    // Random traffic with miss bursts.
    miss_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (miss_left > 0) miss_left--;
      else if ($urandom_range(0, 7) == 0) miss_left = $urandom_range(1, 6);
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, $urandom,
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
            $urandom, $urandom, miss_left > 0, $urandom_range(0, 1) == 1);
    end

    for (int i = 0; i < 4; i++) idle(1'b0, 1'b1);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
